// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^8) field constants for the RS/BCH codebase.
package gf_pkg;
    localparam int       GF_W       = 8;
    localparam logic [8:0] GF_POLY  = 9'h11D;
    localparam int       GF_MUL_LAT = 2;
endpackage

// File: rtl/gf_poly_mul_mastrovito_8.sv
// gf_poly_mul_mastrovito_8: combinational GF(2^8) multiplier, p = a*b mod GF_POLY.
module gf_poly_mul_mastrovito_8
    import gf_pkg::*;
(
    input  logic [GF_W-1:0] a,
    input  logic [GF_W-1:0] b,
    output logic [GF_W-1:0] p
);
    logic [GF_W-1:0] col [GF_W];
    // col[i] = a*x^i mod P; the product is the b-weighted XOR of these columns
    always_comb begin
        col[0] = a;
        for (int i = 1; i < GF_W; i++)
            col[i] = {col[i-1][GF_W-2:0], 1'b0} ^ (col[i-1][GF_W-1] ? GF_POLY[GF_W-1:0] : '0);
        p = '0;
        for (int i = 0; i < GF_W; i++)
            p = p ^ (b[i] ? col[i] : '0);
    end
endmodule

// File: rtl/gf_rr_arbiter.sv
// gf_rr_arbiter: round-robin search of valid starting at ptr, one-hot grant plus index.
module gf_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  g
);
    logic            hit_hi;
    logic [ID_W-1:0] g_hi;
    logic [ID_W-1:0] g_lo;
    // lowest valid at or above ptr wins; otherwise wrap to the lowest valid overall
    always_comb begin
        hit_hi = 1'b0;
        g_hi   = '0;
        g_lo   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid[i]) g_lo = ID_W'(i);
            if (valid[i] && ID_W'(i) >= ptr) begin
                g_hi   = ID_W'(i);
                hit_hi = 1'b1;
            end
        end
        g     = hit_hi ? g_hi : g_lo;
        grant = |valid ? (N_REQ'(1) << g) : '0;
    end
endmodule

// File: rtl/gf_mul_arbiter_8.sv
// gf_mul_arbiter_8: shares one GF(2^8) multiplier among N_REQ requesters,
// round-robin issue, 2-cycle tagged pipeline, broadcast response bus.
module gf_mul_arbiter_8
    import gf_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [GF_W*N_REQ-1:0] req_a,
    input  logic [GF_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [GF_W-1:0]       rsp_data,
    output logic [GF_MUL_LAT:0]   in_flight
);
    localparam int IF_W = GF_MUL_LAT + 1;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  g, ptr_q, ptr_d, id1_q, id1_d, rsp_id_q, rsp_id_d;
    logic [GF_W-1:0]  a_q, a_d, b_q, b_d, prod, rsp_data_q, rsp_data_d;
    logic             xfer, v1_q, v1_d, rsp_valid_q, rsp_valid_d;

    gf_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .g     (g)
    );

    gf_poly_mul_mastrovito_8 u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    always_comb begin
        req_ready = reset ? '0 : grant;
        xfer      = |(req_valid & req_ready);
        ptr_d     = xfer ? ((g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1) : ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                a_d = req_a[i*GF_W +: GF_W];
                b_d = req_b[i*GF_W +: GF_W];
            end
        end
        v1_d        = xfer;
        id1_d       = xfer ? g : id1_q;
        rsp_valid_d = v1_q;
        rsp_id_d    = v1_q ? id1_q : rsp_id_q;
        rsp_data_d  = v1_q ? prod : rsp_data_q;
        rsp_valid   = rsp_valid_q;
        rsp_id      = rsp_id_q;
        rsp_data    = rsp_data_q;
        in_flight   = IF_W'(v1_q) + IF_W'(rsp_valid_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id1_q       <= '0;
            v1_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id1_q       <= id1_d;
            v1_q        <= v1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule
